lvl_states_ldst: RTL and testbench



---
 rtl/lvl_states_ldst_if.sv | 28 ++
 rtl/lvl_states_ldst.sv | 142 ++++++++++++++
 tb/tb_lvl_states_ldst.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/lvl_states_ldst_if.sv
// RAM-side bus of the level-state load/update controller.
// The controller drives the master modport; the global level-state RAM is the slave.
interface lvl_states_ldst_if #(
    parameter int unsigned WIDTH_LVL        = 16,
    parameter int unsigned WIDTH_LVL_STATES = 11
);
    logic                        ram_rd;
    logic                        ram_wr;
    logic [WIDTH_LVL-1:0]        ram_addr;
    logic [WIDTH_LVL_STATES-1:0] ram_wdata;
    logic [WIDTH_LVL_STATES-1:0] ram_rdata;

    modport master (
        output ram_rd,
        output ram_wr,
        output ram_addr,
        output ram_wdata,
        input  ram_rdata
    );

    modport slave (
        input  ram_rd,
        input  ram_wr,
        input  ram_addr,
        input  ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/lvl_states_ldst.sv
// Loads NUM_LVLS level states from the global RAM into the engine slots on a bin switch,
// and writes a snapshot of the engine's level states back to the RAM on bin exit.
module lvl_states_ldst #(
    parameter int unsigned NUM_LVLS         = 4,
    parameter int unsigned WIDTH_LVL_STATES = 11,
    parameter int unsigned WIDTH_LVL        = 16,
    parameter int unsigned WIDTH_BIN        = 10
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_load_i,
    input  logic                                 start_update_i,
    input  logic [WIDTH_LVL-1:0]                 base_lvl_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [NUM_LVLS-1:0]                  wr_states_o,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,
    lvl_states_ldst_if.master                    ram
);
    localparam int unsigned KW = (NUM_LVLS > 1) ? $clog2(NUM_LVLS) : 1;
    localparam int unsigned SW = WIDTH_LVL_STATES * NUM_LVLS;

    if (WIDTH_LVL_STATES != WIDTH_BIN + 1) begin : g_bad_width
        $error("WIDTH_LVL_STATES must equal WIDTH_BIN + 1");
    end

    typedef enum logic [2:0] {
        StIdle, StLoad, StLoadTail, StUpdate, StDone
    } state_e;

    state_e                      state_q, state_d;
    logic [KW-1:0]               k_q, k_d;
    logic [WIDTH_LVL-1:0]        base_q, base_d;
    logic [SW-1:0]               snap_q, snap_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        rd_q, rd_d;
    logic                        wr_q, wr_d;
    logic [WIDTH_LVL-1:0]        addr_q, addr_d;
    logic [WIDTH_LVL_STATES-1:0] wdata_q, wdata_d;
    logic [NUM_LVLS-1:0]         wr_states_q, wr_states_d;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        base_d  = base_q;
        snap_d  = snap_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                // Update has priority; a coincident load is dropped.
                if (start_update_i) begin
                    state_d = StUpdate;
                    k_d     = '0;
                    base_d  = base_lvl_i;
                    snap_d  = lvl_states_i;
                end else if (start_load_i) begin
                    state_d = StLoad;
                    k_d     = '0;
                    base_d  = base_lvl_i;
                end
            end
            StLoad: begin
                if (k_q == KW'(NUM_LVLS - 1)) state_d = StLoadTail;
                else                          k_d     = k_q + 1'b1;
            end
            StLoadTail: state_d = StDone;
            StUpdate: begin
                if (k_q == KW'(NUM_LVLS - 1)) state_d = StDone;
                else                          k_d     = k_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output registers are loaded from the next state so they line up with state_q.
    always_comb begin
        rd_d    = (state_d == StLoad);
        wr_d    = (state_d == StUpdate);
        busy_d  = (state_d == StLoad) || (state_d == StLoadTail) || (state_d == StUpdate);
        done_d  = (state_d == StDone);
        addr_d  = (rd_d || wr_d) ? base_d + WIDTH_LVL'(k_d) : '0;
        wdata_d = '0;
        wr_states_d = '0;
        for (int unsigned i = 0; i < NUM_LVLS; i++) begin
            if (wr_d && (k_d == KW'(NUM_LVLS - 1 - i))) begin
                wdata_d = snap_d[i*WIDTH_LVL_STATES +: WIDTH_LVL_STATES];
            end
            // Read issued for slot k this cycle returns next cycle, so strobe slot k then.
            if ((state_q == StLoad) && (k_q == KW'(NUM_LVLS - 1 - i))) begin
                wr_states_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            k_q         <= '0;
            base_q      <= '0;
            snap_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_states_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            base_q      <= base_d;
            snap_q      <= snap_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_states_q <= wr_states_d;
        end
    end

    // RAM data arrives in the strobe cycle itself, so it is steered by the registered strobe.
    always_comb begin
        lvl_states_o = '0;
        for (int unsigned i = 0; i < NUM_LVLS; i++) begin
            if (wr_states_q[i]) begin
                lvl_states_o[i*WIDTH_LVL_STATES +: WIDTH_LVL_STATES] = ram.ram_rdata;
            end
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign wr_states_o   = wr_states_q;
    assign ram.ram_rd    = rd_q;
    assign ram.ram_wr    = wr_q;
    assign ram.ram_addr  = addr_q;
    assign ram.ram_wdata = wdata_q;
endmodule

// File: tb/tb_lvl_states_ldst.sv
// Directed bench for lvl_states_ldst: RAM model plus queue scoreboard of expected
// RAM reads, RAM writes and engine slot writes.
module tb_lvl_states_ldst;
    localparam int unsigned N  = 4;
    localparam int unsigned W  = 11;
    localparam int unsigned AW = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start_load = 1'b0;
    logic           start_update = 1'b0;
    logic [AW-1:0]  base_lvl = '0;
    logic           busy, done;
    logic [N-1:0]   wr_states;
    logic [W*N-1:0] states_out;
    logic [W*N-1:0] states_in = '0;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]   mem [0:65535];
    logic [AW-1:0]  exp_rd[$];
    logic [AW-1:0]  exp_wr_addr[$];
    logic [W-1:0]   exp_wr_data[$];
    logic [N-1:0]   exp_strb[$];
    logic [W*N-1:0] exp_states[$];

    lvl_states_ldst_if #(.WIDTH_LVL(AW), .WIDTH_LVL_STATES(W)) ram ();

    lvl_states_ldst #(
        .NUM_LVLS(N), .WIDTH_LVL_STATES(W), .WIDTH_LVL(AW), .WIDTH_BIN(10)
    ) dut (
        .clk(clk), .rst(rst),
        .start_load_i(start_load), .start_update_i(start_update),
        .base_lvl_i(base_lvl), .busy_o(busy), .done_o(done),
        .wr_states_o(wr_states), .lvl_states_o(states_out), .lvl_states_i(states_in),
        .ram(ram)
    );

    always #5 clk = ~clk;

    // RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram.ram_rd === 1'b1) ram.ram_rdata <= mem[ram.ram_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe seen must match the head of its queue.
    always @(negedge clk) begin
        check("rd_wr_exclusive", {63'd0, ram.ram_rd & ram.ram_wr}, 64'd0);
        if (ram.ram_rd !== 1'b0) begin
            if (exp_rd.size() == 0) check("rd_unexpected", {63'd0, ram.ram_rd}, 64'd0);
            else check("rd_addr", {48'd0, ram.ram_addr}, {48'd0, exp_rd.pop_front()});
        end
        if (ram.ram_wr !== 1'b0) begin
            if (exp_wr_addr.size() == 0) check("wr_unexpected", {63'd0, ram.ram_wr}, 64'd0);
            else begin
                check("wr_addr", {48'd0, ram.ram_addr}, {48'd0, exp_wr_addr.pop_front()});
                check("wr_data", {53'd0, ram.ram_wdata}, {53'd0, exp_wr_data.pop_front()});
            end
        end
        if (wr_states !== '0) begin
            if (exp_strb.size() == 0) check("slot_unexpected", {60'd0, wr_states}, 64'd0);
            else begin
                check("slot_strobe", {60'd0, wr_states}, {60'd0, exp_strb.pop_front()});
                check("slot_states", {20'd0, states_out}, {20'd0, exp_states.pop_front()});
            end
        end else begin
            check("states_idle_zero", {20'd0, states_out}, 64'd0);
        end
    end

    task automatic push_load(input logic [AW-1:0] base);
        logic [AW-1:0]  a;
        logic [W*N-1:0] st;
        for (int k = 0; k < N; k++) begin
            a  = base + AW'(k);
            st = '0;
            st[(N-1-k)*W +: W] = mem[a];
            exp_rd.push_back(a);
            exp_strb.push_back(N'(1) << (N-1-k));
            exp_states.push_back(st);
        end
    endtask

    task automatic push_update(input logic [AW-1:0] base, input logic [W*N-1:0] v);
        for (int k = 0; k < N; k++) begin
            exp_wr_addr.push_back(base + AW'(k));
            exp_wr_data.push_back(v[(N-1-k)*W +: W]);
        end
    endtask

    // Caller sits at the negedge of cycle T+start_n; reports the offset where done_o rose.
    task automatic wait_done(input int start_n, input int exp_n, input string tag);
        int n = start_n;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n), 64'(exp_n));
    endtask

    task automatic check_queues(input string tag);
        check({tag, "_rd_q"}, 64'(exp_rd.size()), 64'd0);
        check({tag, "_wr_q"}, 64'(exp_wr_addr.size()), 64'd0);
        check({tag, "_slot_q"}, 64'(exp_strb.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
        check({tag, "_wr_states"}, {60'd0, wr_states}, 64'd0);
        check({tag, "_rd"}, {63'd0, ram.ram_rd}, 64'd0);
        check({tag, "_wr"}, {63'd0, ram.ram_wr}, 64'd0);
        check({tag, "_addr"}, {48'd0, ram.ram_addr}, 64'd0);
        check({tag, "_wdata"}, {53'd0, ram.ram_wdata}, 64'd0);
    endtask

    initial begin
        mem[5] = 11'h011; mem[6] = 11'h022; mem[7] = 11'h033; mem[8] = 11'h044;
        mem[16'hFFFE] = 11'h1A1; mem[16'hFFFF] = 11'h2B2;
        mem[16'h0000] = 11'h3C3; mem[16'h0001] = 11'h4D4;
        for (int i = 40; i < 44; i++) mem[i] = W'(i * 7 + 3);
        for (int i = 50; i < 54; i++) mem[i] = W'(i * 13 + 1);

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Load, base 5
        push_load(16'd5);
        start_load = 1'b1; base_lvl = 16'd5;
        @(negedge clk);
        start_load = 1'b0;
        check("load_busy_t1", {63'd0, busy}, 64'd1);
        wait_done(1, 6, "load_done_t6");
        check_queues("load");
        @(negedge clk);
        check("load_idle_busy", {63'd0, busy}, 64'd0);

        // Update, base 9; input changed after accept must not matter
        states_in = {11'h7FF, 11'h001, 11'h400, 11'h155};
        push_update(16'd9, states_in);
        start_update = 1'b1; base_lvl = 16'd9;
        @(negedge clk);
        start_update = 1'b0;
        states_in = {11'h0AA, 11'h0BB, 11'h0CC, 11'h0DD};
        wait_done(1, 5, "update_done_t5");
        check_queues("update");
        @(negedge clk);

        // Wrap-around load
        push_load(16'hFFFE);
        start_load = 1'b1; base_lvl = 16'hFFFE;
        @(negedge clk);
        start_load = 1'b0;
        wait_done(1, 6, "wrap_done_t6");
        check_queues("wrap");
        @(negedge clk);

        // Simultaneous requests: update wins; a start while busy is ignored
        states_in = {11'h123, 11'h456, 11'h789, 11'h0F0};
        push_update(16'd20, states_in);
        start_load = 1'b1; start_update = 1'b1; base_lvl = 16'd20;
        @(negedge clk);
        start_load = 1'b0; start_update = 1'b0;
        @(negedge clk);
        start_load = 1'b1; base_lvl = 16'd5;
        @(negedge clk);
        start_load = 1'b0;
        wait_done(3, 5, "simul_done_t5");
        repeat (3) @(negedge clk);
        check("simul_idle_busy", {63'd0, busy}, 64'd0);
        check_queues("simul");

        // Reset in the middle of a load
        push_load(16'd40);
        start_load = 1'b1; base_lvl = 16'd40;
        @(negedge clk);
        start_load = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        void'(exp_rd.pop_back());
        void'(exp_strb.pop_back());   void'(exp_strb.pop_back());
        void'(exp_states.pop_back()); void'(exp_states.pop_back());
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_queues("midreset");
        push_load(16'd40);
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
        wait_done(7, 12, "postreset_done_t12");
        check_queues("postreset");
        @(negedge clk);

        // Back-to-back: load accepted in the done cycle of an update
        states_in = {11'h321, 11'h654, 11'h087, 11'h7E7};
        push_update(16'd100, states_in);
        start_update = 1'b1; base_lvl = 16'd100;
        @(negedge clk);
        start_update = 1'b0;
        wait_done(1, 5, "b2b_update_done");
        push_load(16'd50);
        start_load = 1'b1; base_lvl = 16'd50;
        @(negedge clk);
        start_load = 1'b0;
        check("b2b_rd_next", {63'd0, ram.ram_rd}, 64'd1);
        wait_done(1, 6, "b2b_load_done");
        repeat (2) @(negedge clk);
        check_queues("b2b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
